// File: rtl/gba_gpu_vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its CPU/DMA and drawer requesters, and the VRAM macro.
// master = requester/VRAM side, slave = arbiter.
interface gba_gpu_vram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 14
);
  logic                      vram_block_mode;
  logic                      cpu_req;
  logic                      cpu_we;
  logic [3:0]                cpu_be;
  logic [ADDR_W-1:0]         cpu_addr;
  logic [31:0]               cpu_wdata;
  logic                      cpu_gnt;
  logic                      cpu_rvalid;
  logic [31:0]               cpu_rdata;
  logic                      vram_blocked;
  logic [NUM_REQ-1:0]        drw_req;
  logic [NUM_REQ*ADDR_W-1:0] drw_addr;
  logic [NUM_REQ-1:0]        drw_gnt;
  logic [NUM_REQ-1:0]        drw_rvalid;
  logic [31:0]               drw_rdata;
  logic [ADDR_W-1:0]         ram_addr;
  logic                      ram_we;
  logic [3:0]                ram_be;
  logic [31:0]               ram_wdata;
  logic [31:0]               ram_rdata;

  modport master (
    output vram_block_mode, cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
           drw_req, drw_addr, ram_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vram_blocked, drw_gnt, drw_rvalid,
           drw_rdata, ram_addr, ram_we, ram_be, ram_wdata
  );

  modport slave (
    input  vram_block_mode, cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
           drw_req, drw_addr, ram_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vram_blocked, drw_gnt, drw_rvalid,
           drw_rdata, ram_addr, ram_we, ram_be, ram_wdata
  );
endinterface

// File: rtl/gba_gpu_vram_arbiter.sv
// Single-port VRAM arbiter: CPU/DMA port vs NUM_REQ drawer fetch engines, one access per
// cycle, with read-return tags carried alongside the VRAM read latency.
module gba_gpu_vram_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = 14,
  parameter int READ_LAT     = 2,
  parameter int CPU_MAX_WAIT = 8
) (
  input logic                   fclk,
  input logic                   reset,
  gba_gpu_vram_arbiter_if.slave bus
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);

  typedef enum logic {CPU_PRIO, DRAW_PRIO} state_e;

  typedef struct packed {
    logic             valid;
    logic             is_cpu;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_e             state_q;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic               ram_we_q;
  logic [3:0]         ram_be_q;
  logic [31:0]        ram_wdata_q;
  tag_t               tag_q [0:READ_LAT];
  tag_t               tag_d, tag_out;
  logic               cpu_pend_q;
  logic [NUM_REQ-1:0] drw_pend_q;

  logic               drw_any, cpu_win, cpu_gnt_w, drw_win, pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  drw_sel_addr;
  logic [NUM_REQ-1:0] drw_gnt_w, drw_rvalid_w;

  // Round-robin search over drawer requests starting at rr_ptr.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_found && bus.drw_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign drw_any      = |bus.drw_req;
  assign cpu_win      = bus.cpu_req & ((state_q == CPU_PRIO) | ~drw_any |
                                       (wait_cnt_q == WAIT_W'(CPU_MAX_WAIT)));
  assign cpu_gnt_w    = cpu_win & ~reset;
  assign drw_win      = drw_any & ~cpu_win & ~reset;
  assign rr_ptr_d     = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign drw_sel_addr = bus.drw_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign tag_out      = tag_q[READ_LAT];

  always_comb begin
    tag_d.valid  = (cpu_gnt_w & ~bus.cpu_we) | drw_win;
    tag_d.is_cpu = cpu_gnt_w;
    tag_d.idx    = pick_idx;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign drw_gnt_w[gi]    = drw_win & (pick_idx == IDX_W'(gi));
      assign drw_rvalid_w[gi] = tag_out.valid & ~tag_out.is_cpu & ~reset &
                                (tag_out.idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q     <= CPU_PRIO;
      rr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_wdata_q <= '0;
      for (int k = 0; k <= READ_LAT; k++) tag_q[k] <= '0;
    end else begin
      case (state_q)
        CPU_PRIO:  if (bus.vram_block_mode)  state_q <= DRAW_PRIO;
        DRAW_PRIO: if (!bus.vram_block_mode) state_q <= CPU_PRIO;
        default:                             state_q <= CPU_PRIO;
      endcase
      ram_we_q <= 1'b0;
      if (cpu_gnt_w) begin
        ram_addr_q  <= bus.cpu_addr;
        ram_we_q    <= bus.cpu_we;
        ram_be_q    <= bus.cpu_be;
        ram_wdata_q <= bus.cpu_wdata;
      end else if (drw_win) begin
        ram_addr_q <= drw_sel_addr;
        ram_be_q   <= 4'hF;
        rr_ptr_q   <= rr_ptr_d;
      end
      if (!bus.cpu_req || cpu_gnt_w)
        wait_cnt_q <= '0;
      else if (wait_cnt_q != WAIT_W'(CPU_MAX_WAIT))
        wait_cnt_q <= wait_cnt_q + 1'b1;
      tag_q[0] <= tag_d;
      for (int k = 1; k <= READ_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // A requester that was left waiting last cycle must still be requesting now.
  always_ff @(posedge fclk) begin
    if (reset) begin
      cpu_pend_q <= 1'b0;
      drw_pend_q <= '0;
    end else begin
      cpu_pend_q <= bus.cpu_req & ~cpu_gnt_w;
      drw_pend_q <= bus.drw_req & ~drw_gnt_w;
      assert (!cpu_pend_q || bus.cpu_req);
      assert ((drw_pend_q & ~bus.drw_req) == '0);
    end
  end

  assign bus.cpu_gnt      = cpu_gnt_w;
  assign bus.drw_gnt      = drw_gnt_w;
  assign bus.vram_blocked = bus.cpu_req & ~cpu_gnt_w & ~reset;
  assign bus.cpu_rvalid   = tag_out.valid & tag_out.is_cpu & ~reset;
  assign bus.cpu_rdata    = bus.cpu_rvalid ? bus.ram_rdata : 32'h0;
  assign bus.drw_rvalid   = drw_rvalid_w;
  assign bus.drw_rdata    = (|drw_rvalid_w) ? bus.ram_rdata : 32'h0;
  assign bus.ram_addr     = reset ? '0 : ram_addr_q;
  assign bus.ram_we       = ram_we_q & ~reset;
  assign bus.ram_be       = reset ? 4'h0 : ram_be_q;
  assign bus.ram_wdata    = reset ? 32'h0 : ram_wdata_q;
endmodule
